// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared MIPS datapath definitions used by the register file and its
// scoreboard: special register numbers, write-back source and destination
// encodings, and the architectural register/word typedefs.
// Configuration macro (consumed by the register file, not by this package):
//   REGFILE_BYPASS_EN - forward same-cycle write-back data to the read ports.
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

  // Write-back source selection
  localparam logic [1:0] WB_REGS = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;

  // Write-back destination selection
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

endpackage

// File: rtl/mips_scoreboard.sv
// ---------------------------------------------------------------------------
// mips_scoreboard
// Tracks registers that are destinations of outstanding multi-cycle loads and
// raises a stall when decode consumes one of them.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   rs_addr/rs_used     - read port A address and "consumed this cycle"
//   rt_addr/rt_used     - read port B address and "consumed this cycle"
//   we, wa              - write-back valid and destination (clears pending)
//   ld_issue, ld_dest   - load issued and its destination (sets pending)
//   stall               - decode must hold
//   pending             - per-register outstanding-load bits
// Configuration macro: REGFILE_BYPASS_EN - a register whose load returns this
// cycle is not treated as a hazard.
// ---------------------------------------------------------------------------
module mips_scoreboard
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_addr,
  input  logic             rs_used,
  input  logic [AW-1:0]    rt_addr,
  input  logic             rt_used,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_dest,
  output logic             stall,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic             hazA, hazB;
  logic             ldAccept;

  // Hazard per read port; with bypass a register being written back right
  // now is already satisfied by the forwarded data.
  always_comb begin
    hazA = pending_q[rs_addr];
    hazB = pending_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (we && (wa == rs_addr)) hazA = 1'b0;
    if (we && (wa == rt_addr)) hazB = 1'b0;
`endif
  end

  assign stall = (rs_used && hazA) || (rt_used && hazB);

  // A stalled decode has not really issued, so its load is dropped.
  assign ldAccept = ld_issue && !stall;

  // Clear on write-back first, then set on load issue so that a new load to
  // the same register in the same cycle stays outstanding. Register 0 is
  // never pending.
  always_comb begin
    pending_d = pending_q;
    for (int r = 1; r < NREGS; r++) begin
      if (we && (wa == AW'(r)))            pending_d[r] = 1'b0;
      if (ldAccept && (ld_dest == AW'(r))) pending_d[r] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/mips_regfile_sb.sv
// ---------------------------------------------------------------------------
// mips_regfile_sb
// Register file with two combinational read ports and one write-back port,
// plus a load scoreboard that stalls decode on outstanding load results.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   rs_addr/rs_used     - read port A address / consumed; rs_data result
//   rt_addr/rt_used     - read port B address / consumed; rt_data result
//   we, wa, wd          - write-back valid, destination, data
//   ld_issue, ld_dest   - load issued this cycle and its destination
//   stall               - decode must hold
//   pending             - scoreboard bits for debug
// Configuration macro: REGFILE_BYPASS_EN - reads of the register being
// written this cycle return the write-back data instead of the old value.
// ---------------------------------------------------------------------------
module mips_regfile_sb
  import mips_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_addr,
  input  logic             rs_used,
  output logic [DW-1:0]    rs_data,
  input  logic [AW-1:0]    rt_addr,
  input  logic             rt_used,
  output logic [DW-1:0]    rt_data,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [DW-1:0]    wd,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_dest,
  output logic             stall,
  output logic [NREGS-1:0] pending
);

  logic [DW-1:0] regs_q [NREGS];
  logic          wrEn;

  // Register 0 is hard-wired to zero, so writes to it are dropped.
  assign wrEn = we && (wa != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wrEn) begin
      regs_q[wa] <= wd;
    end
  end

  // Read muxes: address 0 forces zero ahead of any forwarding.
  always_comb begin
    rs_data = regs_q[rs_addr];
    rt_data = regs_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wrEn && (wa == rs_addr)) rs_data = wd;
    if (wrEn && (wa == rt_addr)) rt_data = wd;
`endif
    if (rs_addr == AW'(REG_ZERO)) rs_data = '0;
    if (rt_addr == AW'(REG_ZERO)) rt_data = '0;
  end

  mips_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rs_used  (rs_used),
    .rt_addr  (rt_addr),
    .rt_used  (rt_used),
    .we       (we),
    .wa       (wa),
    .ld_issue (ld_issue),
    .ld_dest  (ld_dest),
    .stall    (stall),
    .pending  (pending)
  );

endmodule

// File: tb/tb_mips_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_mips_regfile_sb
// Directed bench for mips_regfile_sb. Expected values are queued when a step
// is driven and drained against the DUT outputs shortly after the inputs
// settle. Expectations follow REGFILE_BYPASS_EN when the macro is defined.
// ---------------------------------------------------------------------------
module tb_mips_regfile_sb;

  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int AW    = 5;

  localparam int SEL_RS      = 0;
  localparam int SEL_RT      = 1;
  localparam int SEL_STALL   = 2;
  localparam int SEL_PENDING = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [AW-1:0]    rs_addr, rt_addr, wa, ld_dest;
  logic             rs_used, rt_used, we, ld_issue;
  logic [DW-1:0]    wd, rs_data, rt_data;
  logic             stall;
  logic [NREGS-1:0] pending;

  int compareCount = 0;
  int failCount    = 0;

  int          expSel [$];
  logic [31:0] expVal [$];
  string       expTag [$];

  bit bypassOn;

  always #5 clk = ~clk;

  mips_regfile_sb #(
    .NREGS (NREGS),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rs_used  (rs_used),
    .rs_data  (rs_data),
    .rt_addr  (rt_addr),
    .rt_used  (rt_used),
    .rt_data  (rt_data),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .ld_issue (ld_issue),
    .ld_dest  (ld_dest),
    .stall    (stall),
    .pending  (pending)
  );

  // Advance to the next falling edge and drive write-back / load / read ports.
  task automatic applyStimulus(input logic wEn, input logic [AW-1:0] wAddr,
                               input logic [DW-1:0] wData, input logic ldIss,
                               input logic [AW-1:0] ldDst,
                               input logic [AW-1:0] aAddr, input logic aUsed,
                               input logic [AW-1:0] bAddr, input logic bUsed);
    @(negedge clk);
    we       = wEn;
    wa       = wAddr;
    wd       = wData;
    ld_issue = ldIss;
    ld_dest  = ldDst;
    rs_addr  = aAddr;
    rs_used  = aUsed;
    rt_addr  = bAddr;
    rt_used  = bUsed;
  endtask

  task automatic expectOut(input int sel, input string tag, input logic [31:0] val);
    expSel.push_back(sel);
    expTag.push_back(tag);
    expVal.push_back(val);
  endtask

  // Let the combinational outputs settle, then drain every queued expectation.
  task automatic checkOutput();
    int          sel;
    string       tag;
    logic [31:0] exp;
    logic [31:0] obs;
    #1;
    while (expSel.size() > 0) begin
      sel = expSel.pop_front();
      tag = expTag.pop_front();
      exp = expVal.pop_front();
      case (sel)
        SEL_RS:    obs = rs_data;
        SEL_RT:    obs = rt_data;
        SEL_STALL: obs = {31'd0, stall};
        default:   obs = pending;
      endcase
      compareCount++;
      assert (obs === exp)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  initial begin
`ifdef REGFILE_BYPASS_EN
    bypassOn = 1'b1;
`else
    bypassOn = 1'b0;
`endif
    rst_n = 1'b0;
    we = 0; wa = 0; wd = 0; ld_issue = 0; ld_dest = 0;
    rs_addr = 5; rs_used = 1; rt_addr = 7; rt_used = 1;

    // Reset state
    expectOut(SEL_RS, "reset_rs", 32'h0);
    expectOut(SEL_RT, "reset_rt", 32'h0);
    expectOut(SEL_STALL, "reset_stall", 32'h0);
    expectOut(SEL_PENDING, "reset_pending", 32'h0);
    checkOutput();

    // Write reg 5, read it back the next cycle
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 5, 1, 0, 0);
    expectOut(SEL_RS, "read_r5", 32'hDEADBEEF);
    expectOut(SEL_STALL, "read_r5_stall", 32'h0);
    checkOutput();

    // Register 0 ignores writes and loads
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 0);
    expectOut(SEL_RS, "r0_reads_zero", 32'h0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    expectOut(SEL_PENDING, "r0_never_pending", 32'h0);
    expectOut(SEL_STALL, "r0_no_stall", 32'h0);
    checkOutput();

    // Load-use on reg 8
    applyStimulus(0, 0, 0, 1, 8, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8, 1);
    expectOut(SEL_STALL, "loaduse_stall", 32'h1);
    expectOut(SEL_PENDING, "loaduse_pending", 32'h0000_0100);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8, 0);
    expectOut(SEL_STALL, "unused_port_no_stall", 32'h0);
    checkOutput();
    applyStimulus(1, 8, 32'h12345678, 0, 0, 0, 0, 8, 1);
    expectOut(SEL_STALL, "wb_cycle_stall", bypassOn ? 32'h0 : 32'h1);
    expectOut(SEL_RT, "wb_cycle_rt", bypassOn ? 32'h12345678 : 32'h0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 8, 1);
    expectOut(SEL_STALL, "after_wb_stall", 32'h0);
    expectOut(SEL_RT, "after_wb_rt", 32'h12345678);
    expectOut(SEL_PENDING, "after_wb_pending", 32'h0);
    checkOutput();

    // Same-cycle set and clear on reg 9: set wins, data lands
    applyStimulus(1, 9, 32'hCAFEF00D, 1, 9, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 9, 0, 0, 0);
    expectOut(SEL_PENDING, "setclr_pending", 32'h0000_0200);
    expectOut(SEL_RS, "setclr_data", 32'hCAFEF00D);
    checkOutput();

    // A stalled decode drops its load
    applyStimulus(0, 0, 0, 1, 10, 9, 1, 0, 0);
    expectOut(SEL_STALL, "stalled_issue_stall", 32'h1);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectOut(SEL_PENDING, "stalled_issue_dropped", 32'h0000_0200);
    checkOutput();

    // Same-cycle read and write of reg 3
    applyStimulus(1, 3, 32'hA5A5A5A5, 0, 0, 3, 0, 0, 0);
    expectOut(SEL_RS, "rw_same_cycle", bypassOn ? 32'hA5A5A5A5 : 32'h0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 3, 0, 0, 0);
    expectOut(SEL_RS, "rw_next_cycle", 32'hA5A5A5A5);
    checkOutput();

    // Mid-operation reset with regs 4, 7 (and 9) pending
    applyStimulus(0, 0, 0, 1, 4, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 4, 1, 7, 1);
    expectOut(SEL_PENDING, "pre_reset_pending", 32'h0000_0290);
    expectOut(SEL_STALL, "pre_reset_stall", 32'h1);
    checkOutput();
    rst_n = 1'b0;
    expectOut(SEL_PENDING, "midreset_pending", 32'h0);
    expectOut(SEL_STALL, "midreset_stall", 32'h0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 5, 1, 3, 1);
    rst_n = 1'b1;
    expectOut(SEL_RS, "post_reset_r5", 32'h0);
    expectOut(SEL_RT, "post_reset_r3", 32'h0);
    expectOut(SEL_STALL, "post_reset_stall", 32'h0);
    checkOutput();
    applyStimulus(0, 0, 0, 0, 0, 9, 1, 8, 1);
    expectOut(SEL_RS, "post_reset_r9", 32'h0);
    expectOut(SEL_RT, "post_reset_r8", 32'h0);
    expectOut(SEL_PENDING, "post_reset_pending", 32'h0);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
